// File: rtl/desc_match_pkg.sv
// desc_match_pkg: shared fixed-point types, limits and FSM encoding for the
// descriptor matcher (desc_match) and its lane multiplier (desc_mac_lanes).
package desc_match_pkg;

  localparam int FRAC_W  = 27;   // fractional bits of Q6.27
  localparam int FIX_W   = 33;   // Q6.27 element / score width
  localparam int TRUNC_W = 39;   // Q12.27 product after dropping 27 LSBs
  localparam int ACC_W   = 45;   // Q18.27 accumulator width

  typedef logic signed [FIX_W-1:0] fix_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam fix_t FIX_MAX = 33'sh0_FFFF_FFFF;
  localparam fix_t FIX_MIN = 33'sh1_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/desc_mac_lanes.sv
// desc_mac_lanes: combinational sum of LANES signed Q6.27 x Q6.27 products,
// each floored to Q12.27 before summing into an accumulator-width value.
module desc_mac_lanes
  import desc_match_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [LANES-1:0][FIX_W-1:0] i_a,
  input  logic [LANES-1:0][FIX_W-1:0] i_b,
  output acc_t                        o_sum
);

  logic signed [2*FIX_W-1:0] w_ext_a [LANES];
  logic signed [2*FIX_W-1:0] w_ext_b [LANES];
  logic signed [2*FIX_W-1:0] w_prod  [LANES];
  logic signed [TRUNC_W-1:0] w_trunc [LANES];
  acc_t                      w_sum;

  // Full-precision signed products; keeping the upper 39 bits of the 66-bit
  // product is an arithmetic right shift by FRAC_W, i.e. floor rounding.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_ext_a[k] = {{FIX_W{i_a[k][FIX_W-1]}}, i_a[k]};
    assign w_ext_b[k] = {{FIX_W{i_b[k][FIX_W-1]}}, i_b[k]};
    assign w_prod[k]  = w_ext_a[k] * w_ext_b[k];
    assign w_trunc[k] = w_prod[k][2*FIX_W-1:FRAC_W];
  end

  // Sign-extend each truncated product and add the lanes together.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_sum = w_sum + {{(ACC_W-TRUNC_W){w_trunc[k][TRUNC_W-1]}}, w_trunc[k]};
    end
  end

  assign o_sum = w_sum;

endmodule

// File: rtl/desc_match.sv
// desc_match: dot-product matcher of normalized descriptors against a stored
// template, with per-frame best-candidate tracking.
// Optional feature macro: DESC_MATCH_DROP_CNT_EN adds a saturating drop_cnt.
module desc_match
  import desc_match_pkg::*;
#(
  parameter int N_ELEM = 64,
  parameter int LANES  = 4,
  parameter int IDX_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         desc_valid,
  input  logic                         template_load,
  input  logic [N_ELEM-1:0][FIX_W-1:0] desc_in,
  input  logic                         frame_start,
  output logic                         busy,
  output logic                         template_valid,
  output logic [FIX_W-1:0]             score,
  output logic                         score_valid,
  output logic [IDX_W-1:0]             cand_idx,
  output logic [FIX_W-1:0]             best_score,
  output logic [IDX_W-1:0]             best_idx,
`ifdef DESC_MATCH_DROP_CNT_EN
  output logic                         best_valid,
  output logic [15:0]                  drop_cnt
`else
  output logic                         best_valid
`endif
);

  localparam int BEATS  = N_ELEM / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EL_W   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  state_t                       r_state;
  logic [BEAT_W-1:0]            r_beat;
  acc_t                         r_acc;
  logic [N_ELEM-1:0][FIX_W-1:0] r_work;
  logic [N_ELEM-1:0][FIX_W-1:0] r_tmpl;
  logic                         r_tmpl_vld;
  fix_t                         r_score;
  logic [IDX_W-1:0]             r_cand_idx;
  logic [IDX_W-1:0]             r_cand_cnt;
  fix_t                         r_best_score;
  logic [IDX_W-1:0]             r_best_idx;
  logic                         r_best_vld;

  logic [EL_W-1:0]              w_base;
  logic [LANES-1:0][FIX_W-1:0]  w_work_lanes;
  logic [LANES-1:0][FIX_W-1:0]  w_tmpl_lanes;
  acc_t                         w_lane_sum;
  acc_t                         w_acc_next;
  fix_t                         w_sat;
  logic                         w_last;
  logic [IDX_W-1:0]             w_idx;

  function automatic fix_t sat_fix(input acc_t a);
    if (a > acc_t'(FIX_MAX)) return FIX_MAX;
    if (a < acc_t'(FIX_MIN)) return FIX_MIN;
    return a[FIX_W-1:0];
  endfunction

  // Select the LANES elements of the current beat from working and template.
  always_comb begin
    w_work_lanes = '0;
    w_tmpl_lanes = '0;
    w_base       = EL_W'(r_beat) * EL_W'(LANES);
    for (int k = 0; k < LANES; k++) begin
      w_work_lanes[k] = r_work[w_base + EL_W'(k)];
      w_tmpl_lanes[k] = r_tmpl[w_base + EL_W'(k)];
    end
  end

  desc_mac_lanes #(.LANES(LANES)) u_lanes (
    .i_a   (w_work_lanes),
    .i_b   (w_tmpl_lanes),
    .o_sum (w_lane_sum)
  );

  // Final-beat result and candidate index; a coincident frame_start makes
  // the completing score candidate 0 of the new frame.
  always_comb begin
    w_acc_next = r_acc + w_lane_sum;
    w_sat      = sat_fix(w_acc_next);
    w_last     = (r_state == ST_MAC) && (r_beat == BEAT_LAST);
    w_idx      = frame_start ? '0 : r_cand_cnt;
  end

  // FSM, template capture, working-register capture and accumulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_beat     <= '0;
      r_acc      <= '0;
      r_work     <= '0;
      r_tmpl     <= '0;
      r_tmpl_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (desc_valid && template_load) begin
            r_tmpl     <= desc_in;
            r_tmpl_vld <= 1'b1;
          end else if (desc_valid && r_tmpl_vld) begin
            r_work  <= desc_in;
            r_beat  <= '0;
            r_acc   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          r_acc  <= w_acc_next;
          r_beat <= r_beat + BEAT_W'(1);
          if (r_beat == BEAT_LAST) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Score register, candidate counter and best-of-frame tracker. The result
  // is registered on the last MAC beat so it is visible throughout DONE; a
  // frame_start seen during DONE re-seats that result as candidate 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_score      <= '0;
      r_cand_idx   <= '0;
      r_cand_cnt   <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_best_vld   <= 1'b0;
    end else if (w_last) begin
      r_score    <= w_sat;
      r_cand_idx <= w_idx;
      r_cand_cnt <= w_idx + IDX_W'(1);
      if (frame_start || !r_best_vld || (w_sat > r_best_score)) begin
        r_best_score <= w_sat;
        r_best_idx   <= w_idx;
        r_best_vld   <= 1'b1;
      end
    end else if (frame_start) begin
      if (r_state == ST_DONE) begin
        r_cand_idx   <= '0;
        r_cand_cnt   <= IDX_W'(1);
        r_best_score <= r_score;
        r_best_idx   <= '0;
        r_best_vld   <= 1'b1;
      end else begin
        r_cand_cnt   <= '0;
        r_best_score <= '0;
        r_best_idx   <= '0;
        r_best_vld   <= 1'b0;
      end
    end
  end

`ifdef DESC_MATCH_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  assign w_drop = desc_valid &&
                  ((r_state != ST_IDLE) || (!template_load && !r_tmpl_vld));

  // Saturating count of descriptors dropped for busy or missing template.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_drop_cnt <= '0;
    end else if (frame_start) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

  assign busy           = (r_state != ST_IDLE);
  assign template_valid = r_tmpl_vld;
  assign score          = r_score;
  assign score_valid    = (r_state == ST_DONE);
  assign cand_idx       = r_cand_idx;
  assign best_score     = r_best_score;
  assign best_idx       = r_best_idx;
  assign best_valid     = r_best_vld;

endmodule

// File: tb/tb_desc_match.sv
// tb_desc_match: directed self-checking bench for desc_match.
module tb_desc_match;

  localparam int N_ELEM = 64;
  localparam int LANES  = 4;
  localparam int IDX_W  = 8;

  localparam logic [32:0] V_EIGHTH  = 33'h0_0100_0000;  //  1/8
  localparam logic [32:0] V_MEIGHTH = 33'h1_FF00_0000;  // -1/8
  localparam logic [32:0] V_FOUR    = 33'h0_2000_0000;  //  4.0
  localparam logic [32:0] V_MFOUR   = 33'h1_E000_0000;  // -4.0
  localparam logic [32:0] V_ONE     = 33'h0_0800_0000;  //  1.0
  localparam logic [32:0] V_LSB     = 33'h0_0000_0001;  //  2^-27
  localparam logic [32:0] V_MLSB    = 33'h1_FFFF_FFFF;  // -2^-27

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    desc_valid;
  logic                    template_load;
  logic [N_ELEM-1:0][32:0] desc_in;
  logic                    frame_start;
  logic                    busy;
  logic                    template_valid;
  logic [32:0]             score;
  logic                    score_valid;
  logic [IDX_W-1:0]        cand_idx;
  logic [32:0]             best_score;
  logic [IDX_W-1:0]        best_idx;
  logic                    best_valid;
`ifdef DESC_MATCH_DROP_CNT_EN
  logic [15:0]             drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  desc_match #(.N_ELEM(N_ELEM), .LANES(LANES), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .desc_valid     (desc_valid),
    .template_load  (template_load),
    .desc_in        (desc_in),
    .frame_start    (frame_start),
    .busy           (busy),
    .template_valid (template_valid),
    .score          (score),
    .score_valid    (score_valid),
    .cand_idx       (cand_idx),
    .best_score     (best_score),
    .best_idx       (best_idx),
`ifdef DESC_MATCH_DROP_CNT_EN
    .best_valid     (best_valid),
    .drop_cnt       (drop_cnt)
`else
    .best_valid     (best_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [32:0] v);
    for (int k = 0; k < N_ELEM; k++) desc_in[k] = v;
  endtask

  task automatic load_tmpl(input logic [32:0] v);
    fill(v);
    desc_valid    = 1'b1;
    template_load = 1'b1;
    step();
    desc_valid    = 1'b0;
    template_load = 1'b0;
    chk("tmpl_valid", 64'(template_valid), 64'd1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(busy),           64'd0);
    chk({tag, "_tvld"},  64'(template_valid), 64'd0);
    chk({tag, "_score"}, 64'(score),          64'd0);
    chk({tag, "_svld"},  64'(score_valid),    64'd0);
    chk({tag, "_cidx"},  64'(cand_idx),       64'd0);
    chk({tag, "_bscr"},  64'(best_score),     64'd0);
    chk({tag, "_bidx"},  64'(best_idx),       64'd0);
    chk({tag, "_bvld"},  64'(best_valid),     64'd0);
  endtask

  // Issue a scoring descriptor in cycle t; returns during cycle t+17.
  task automatic run_desc(input logic [32:0] v);
    fill(v);
    desc_valid = 1'b1;
    step();
    desc_valid = 1'b0;
    chk("busy_t1", 64'(busy), 64'd1);
    repeat (15) step();
    chk("svld_t16", 64'(score_valid), 64'd0);
    step();
    chk("svld_t17", 64'(score_valid), 64'd1);
    chk("busy_t17", 64'(busy), 64'd1);
  endtask

  initial begin
    int sv_cnt;
    rst           = 1'b0;
    desc_valid    = 1'b0;
    template_load = 1'b0;
    frame_start   = 1'b0;
    fill(33'h0);
    repeat (3) step();
    chk_all_zero("rst");
`ifdef DESC_MATCH_DROP_CNT_EN
    chk("rst_drop", 64'(drop_cnt), 64'd0);
`endif
    rst = 1'b1;
    step();

    // Descriptor with no template loaded is dropped.
    fill(V_EIGHTH);
    desc_valid = 1'b1;
    step();
    desc_valid = 1'b0;
    chk("notmpl_busy", 64'(busy), 64'd0);
    sv_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (score_valid) sv_cnt++;
      step();
    end
    chk("notmpl_svcnt", 64'(sv_cnt), 64'd0);
`ifdef DESC_MATCH_DROP_CNT_EN
    chk("notmpl_drop", 64'(drop_cnt), 64'd1);
`endif

    // Template 1/8, descriptor 1/8 -> 1.0.
    load_tmpl(V_EIGHTH);
    chk("tmpl_busy", 64'(busy), 64'd0);
    chk("tmpl_nosv", 64'(score_valid), 64'd0);
    pulse_frame();
`ifdef DESC_MATCH_DROP_CNT_EN
    chk("fs_drop_clr", 64'(drop_cnt), 64'd0);
`endif
    run_desc(V_EIGHTH);
    chk("s1_score", 64'(score), 64'h0_0800_0000);
    chk("s1_cidx",  64'(cand_idx), 64'd0);
    chk("s1_bidx",  64'(best_idx), 64'd0);
    chk("s1_bvld",  64'(best_valid), 64'd1);
    chk("s1_bscr",  64'(best_score), 64'h0_0800_0000);
    step();
    chk("s1_busy_t18", 64'(busy), 64'd0);
    chk("s1_svld_t18", 64'(score_valid), 64'd0);

    // New frame: -1.0, then 1.0 wins, then a tie keeps the earlier index.
    pulse_frame();
    chk("fs_bvld", 64'(best_valid), 64'd0);
    chk("fs_bscr", 64'(best_score), 64'd0);
    run_desc(V_MEIGHTH);
    chk("s2_score", 64'(score), 64'h1_F800_0000);
    chk("s2_cidx",  64'(cand_idx), 64'd0);
    chk("s2_bscr",  64'(best_score), 64'h1_F800_0000);
    step();
    run_desc(V_EIGHTH);
    chk("s3_cidx", 64'(cand_idx), 64'd1);
    chk("s3_bidx", 64'(best_idx), 64'd1);
    chk("s3_bscr", 64'(best_score), 64'h0_0800_0000);
    step();
    run_desc(V_EIGHTH);
    chk("s4_cidx", 64'(cand_idx), 64'd2);
    chk("s4_tie_bidx", 64'(best_idx), 64'd1);
    step();

    // Descriptor arriving at t+5 of an active scoring is ignored.
    fill(V_EIGHTH);
    desc_valid = 1'b1;
    step();
    desc_valid = 1'b0;
    sv_cnt = 0;
    for (int c = 1; c < 22; c++) begin
      if (score_valid) sv_cnt++;
      if (c == 17) begin
        chk("busy_sv17", 64'(score_valid), 64'd1);
        chk("busy_cidx", 64'(cand_idx), 64'd3);
      end
      if (c == 18) chk("busy_t18", 64'(busy), 64'd0);
      desc_valid = (c == 5);
      step();
    end
    desc_valid = 1'b0;
    chk("busy_svcnt", 64'(sv_cnt), 64'd1);
`ifdef DESC_MATCH_DROP_CNT_EN
    chk("busy_drop", 64'(drop_cnt), 64'd1);
`endif

    // Saturation, positive and negative.
    load_tmpl(V_FOUR);
    run_desc(V_FOUR);
    chk("sat_max", 64'(score), 64'h0_FFFF_FFFF);
    chk("sat_max_bidx", 64'(best_idx), 64'd4);
    chk("sat_max_bscr", 64'(best_score), 64'h0_FFFF_FFFF);
    step();
    load_tmpl(V_MFOUR);
    run_desc(V_FOUR);
    chk("sat_min", 64'(score), 64'h1_0000_0000);
    chk("sat_min_bidx", 64'(best_idx), 64'd4);
    step();

    // Floor rounding: each (-2^-27 * 2^-27) product floors to -2^-27.
    load_tmpl(V_LSB);
    run_desc(V_MLSB);
    chk("floor", 64'(score), 64'h1_FFFF_FFC0);
    chk("floor_cidx", 64'(cand_idx), 64'd6);
    step();

    // frame_start coincident with score_valid.
    run_desc(V_MLSB);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fsd_cidx", 64'(cand_idx), 64'd0);
    chk("fsd_bidx", 64'(best_idx), 64'd0);
    chk("fsd_bvld", 64'(best_valid), 64'd1);
    chk("fsd_bscr", 64'(best_score), 64'h1_FFFF_FFC0);
    run_desc(V_ONE);
    chk("fsd2_score", 64'(score), 64'h0_0000_0040);
    chk("fsd2_cidx", 64'(cand_idx), 64'd1);
    chk("fsd2_bidx", 64'(best_idx), 64'd1);
    step();

    // Reset low at t+8 of a scoring.
    fill(V_ONE);
    desc_valid = 1'b1;
    step();
    desc_valid = 1'b0;
    repeat (7) step();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_all_zero("midrst");
`ifdef DESC_MATCH_DROP_CNT_EN
    chk("midrst_drop", 64'(drop_cnt), 64'd0);
`endif
    fill(V_ONE);
    desc_valid = 1'b1;
    step();
    desc_valid = 1'b0;
    chk("postrst_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
